// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared constants and helpers for the MAC processing-element array.
//   - Default parameter values for pe_array_rr / pe_mac_lane.
//   - Saturation bound helpers for an accumulator of width w (w <= 64),
//     returned in the low w bits of a 64-bit word; callers truncate.
package pe_array_pkg;

    localparam int unsigned DEF_NUM_PE   = 8;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_ACC_W    = 32;
    localparam int unsigned DEF_SIGNED   = 1;
    localparam int unsigned DEF_SATURATE = 1;

    function automatic logic [63:0] sat_max_signed(input int unsigned w);
        return {64{1'b1}} >> (65 - w);
    endfunction

    function automatic logic [63:0] sat_min_signed(input int unsigned w);
        return 64'(1) << (w - 1);
    endfunction

    function automatic logic [63:0] sat_max_unsigned(input int unsigned w);
        return {64{1'b1}} >> (64 - w);
    endfunction

    function automatic logic [63:0] sat_min_unsigned(input int unsigned w);
        return (w == 0) ? '0 : '0;
    endfunction

endpackage

// File: rtl/pe_array_rr_lane.sv
// pe_mac_lane: one MAC lane of pe_array_rr.
//   clk, rst  : clock, asynchronous active-low reset
//   beat      : accepted operand beat for this lane
//   last      : beat closes the dot product
//   a, b      : operands
//   clr       : result taken by the output arbiter (frees slot, clears ovf)
//   res       : parked result
//   full      : result slot occupied
//   ovf       : sticky overflow flag for the current dot product
module pe_mac_lane
    import pe_array_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter int unsigned SIGNED   = DEF_SIGNED,
    parameter int unsigned SATURATE = DEF_SATURATE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat,
    input  logic              last,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              clr,
    output logic [ACC_W-1:0]  res,
    output logic              full,
    output logic              ovf
);

    localparam logic [ACC_W-1:0] MAX_V = (SIGNED != 0) ? ACC_W'(sat_max_signed(ACC_W))
                                                       : ACC_W'(sat_max_unsigned(ACC_W));
    localparam logic [ACC_W-1:0] MIN_V = (SIGNED != 0) ? ACC_W'(sat_min_signed(ACC_W))
                                                       : ACC_W'(sat_min_unsigned(ACC_W));

    logic [ACC_W-1:0]    acc;
    logic [2*DATA_W-1:0] ax, bx, prod;
    logic [ACC_W:0]      prod_ext, acc_ext, sum_w;
    logic [ACC_W-1:0]    sum;
    logic                sgn_a, sgn_b, sgn_p, sgn_acc, ovf_now;

    // Operands widened to the product width first, so the low 2*DATA_W bits
    // of an ordinary multiply are correct for both signed and unsigned modes.
    assign sgn_a   = (SIGNED != 0) && a[DATA_W-1];
    assign sgn_b   = (SIGNED != 0) && b[DATA_W-1];
    assign ax      = {{DATA_W{sgn_a}}, a};
    assign bx      = {{DATA_W{sgn_b}}, b};
    assign prod    = ax * bx;

    assign sgn_p    = (SIGNED != 0) && prod[2*DATA_W-1];
    assign sgn_acc  = (SIGNED != 0) && acc[ACC_W-1];
    assign prod_ext = {{(ACC_W + 1 - 2*DATA_W){sgn_p}}, prod};
    assign acc_ext  = {sgn_acc, acc};
    assign sum_w    = acc_ext + prod_ext;

    // Signed: the two top bits disagree when the true result left ACC_W range.
    assign ovf_now = (SIGNED != 0) ? (sum_w[ACC_W] ^ sum_w[ACC_W-1]) : sum_w[ACC_W];

    always_comb begin
        sum = sum_w[ACC_W-1:0];
        if (ovf_now && (SATURATE != 0)) begin
            sum = ((SIGNED != 0) && sum_w[ACC_W]) ? MIN_V : MAX_V;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            res  <= '0;
            full <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (beat) begin
                if (last) begin
                    res  <= sum;
                    full <= 1'b1;
                    acc  <= '0;
                end else begin
                    acc <= sum;
                end
                if (ovf_now) begin
                    ovf <= 1'b1;
                end
            end
            if (clr) begin
                full <= 1'b0;
                ovf  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pe_array_rr.sv
// pe_array_rr: NUM_PE-lane MAC array with round-robin drained result bus.
//   clk, rst              : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand beat handshake; in_sel picks the lane,
//                           in_a/in_b are operands, in_last closes the product
//   out_valid/out_ready   : result handshake; out_data is the dot product,
//                           out_idx the lane that produced it
//   ovf                   : per-lane sticky overflow flag
module pe_array_rr
    import pe_array_pkg::*;
#(
    parameter int unsigned NUM_PE   = DEF_NUM_PE,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter int unsigned SIGNED   = DEF_SIGNED,
    parameter int unsigned SATURATE = DEF_SATURATE,
    parameter int unsigned SEL_W    = $clog2(NUM_PE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [SEL_W-1:0]  out_idx,
    output logic [NUM_PE-1:0] ovf
);

    localparam int unsigned SLOTS = 1 << SEL_W;

    logic [NUM_PE-1:0] full, beat, clr;
    logic [ACC_W-1:0]  res [NUM_PE];
    logic [SLOTS-1:0]  full_ext;
    logic              accept, load, grant_any, grant_vld;
    logic [SEL_W-1:0]  grant, rr_ptr, rr_next;
    int unsigned       scan_idx;

    // Unused index codes read as empty, so an out-of-range beat is taken and
    // dropped (no lane matches it below).
    always_comb begin
        full_ext = '0;
        full_ext[NUM_PE-1:0] = full;
    end

    assign in_ready = ~full_ext[in_sel];
    assign accept   = in_valid & in_ready;

    genvar i;
    generate
        for (i = 0; i < NUM_PE; i++) begin : g_lane
            assign beat[i] = accept && (in_sel == SEL_W'(i));
            assign clr[i]  = grant_vld && (grant == SEL_W'(i));

            pe_mac_lane #(
                .DATA_W  (DATA_W),
                .ACC_W   (ACC_W),
                .SIGNED  (SIGNED),
                .SATURATE(SATURATE)
            ) u_lane (
                .clk (clk),
                .rst (rst),
                .beat(beat[i]),
                .last(in_last),
                .a   (in_a),
                .b   (in_b),
                .clr (clr[i]),
                .res (res[i]),
                .full(full[i]),
                .ovf (ovf[i])
            );
        end
    endgenerate

    // First full lane scanning upward from rr_ptr, wrapping at NUM_PE.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NUM_PE; k++) begin
            scan_idx = (32'(rr_ptr) + k) % NUM_PE;
            if (!grant_any && full[SEL_W'(scan_idx)]) begin
                grant_any = 1'b1;
                grant     = SEL_W'(scan_idx);
            end
        end
    end

    assign load      = ~out_valid | out_ready;
    assign grant_vld = load & grant_any;
    assign rr_next   = (grant == SEL_W'(NUM_PE - 1)) ? '0 : grant + SEL_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= res[grant];
                out_idx   <= grant;
                rr_ptr    <= rr_next;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
